// File: rtl/apb_protocol_pkg.sv
// apb_pkg: shared constants and the master FSM state type for the APB
// demonstrator (master bridge + two register-file slaves).
package apb_pkg;
  localparam int ADDR_W      = 9;   // user/APB address width
  localparam int DATA_W      = 8;   // data width
  localparam int MEM_DEPTH   = 64;  // bytes per slave
  localparam int SLV_SEL_BIT = 8;   // PADDR bit choosing slave 1 / slave 2
  localparam int IDX_W       = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
endpackage

// File: rtl/apb_protocol_if.sv
// apb_protocol_if: user-side request/response bundle of the APB subsystem.
//   transfer, READ_WRITE, apb_write_paddr, apb_write_data, apb_read_paddr:
//     request side, driven by the requester (modport master).
//   PSLVERR, apb_read_data_out: completion status / read data, driven by
//     the APB block (modport slave).
interface apb_protocol_if;
  logic                        transfer;
  logic                        READ_WRITE;
  logic [apb_pkg::ADDR_W-1:0]  apb_write_paddr;
  logic [apb_pkg::DATA_W-1:0]  apb_write_data;
  logic [apb_pkg::ADDR_W-1:0]  apb_read_paddr;
  logic                        PSLVERR;
  logic [apb_pkg::DATA_W-1:0]  apb_read_data_out;

  modport master (
    output transfer, READ_WRITE, apb_write_paddr, apb_write_data, apb_read_paddr,
    input  PSLVERR, apb_read_data_out
  );

  modport slave (
    input  transfer, READ_WRITE, apb_write_paddr, apb_write_data, apb_read_paddr,
    output PSLVERR, apb_read_data_out
  );
endinterface

// File: rtl/apb_protocol_slave.sv
// apb_slave: zero-wait-state APB register file with per-byte written-valid
// bits.
//   PCLK, PRESETn (sync, active high) : clock / reset (clears valid bits)
//   psel, penable, pwrite, paddr, pwdata : APB request (paddr excludes the
//                                          slave-select bit)
//   pready, prdata, pslverr              : APB response (combinational)
// Addresses with paddr[7:6] != 0 are out of range: writes are dropped,
// reads return 0, both flag pslverr. Reading a never-written byte also
// flags pslverr.
module apb_slave
  import apb_pkg::*;
(
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [SLV_SEL_BIT-1:0] paddr,
  input  logic [DATA_W-1:0]      pwdata,
  output logic                   pready,
  output logic [DATA_W-1:0]      prdata,
  output logic                   pslverr
);
  logic [DATA_W-1:0]    mem [MEM_DEPTH];
  logic [MEM_DEPTH-1:0] valid;
  logic [IDX_W-1:0]     idx;
  logic                 bad_addr, access, wr_en, rd_ok;

  assign idx      = paddr[IDX_W-1:0];
  assign bad_addr = |paddr[SLV_SEL_BIT-1:IDX_W];
  assign access   = psel & penable;
  // Reset on the ACCESS-ending edge wins: the write is abandoned.
  assign wr_en    = access & pwrite & ~bad_addr & ~PRESETn;
  assign rd_ok    = access & ~pwrite & ~bad_addr & valid[idx];

  assign pready  = access;
  assign pslverr = access & (bad_addr | (~pwrite & ~valid[idx]));
  assign prdata  = rd_ok ? mem[idx] : '0;

  always_ff @(posedge PCLK) begin
    if (PRESETn)    valid      <= '0;
    else if (wr_en) valid[idx] <= 1'b1;
  end

  // Contents are deliberately not reset; valid bits guard against stale reads.
  always_ff @(posedge PCLK) begin
    if (wr_en) mem[idx] <= pwdata;
  end
endmodule

// File: rtl/apb_protocol.sv
// apb_protocol: APB master bridge plus two identical register-file slaves.
//   PCLK    : clock, all logic on rising edge
//   PRESETn : synchronous active-high reset
//   usr     : user request/response bundle (apb_protocol_if.slave)
// Each user request becomes a SETUP + ACCESS pair (2 cycles). Request fields
// are captured on the edge entering SETUP and held through ACCESS, so the
// user side may change them freely between launches. PADDR[8] picks slave.
module apb_protocol
  import apb_pkg::*;
(
  input  logic           PCLK,
  input  logic           PRESETn,
  apb_protocol_if.slave  usr
);
  apb_state_e         state;
  logic               psel, penable, pwrite;
  logic [ADDR_W-1:0]  paddr;
  logic [DATA_W-1:0]  pwdata;
  logic               pslverr_q;
  logic [DATA_W-1:0]  rdata_q;

  logic               psel1, psel2, pready1, pready2, err1, err2;
  logic [DATA_W-1:0]  prdata1, prdata2, prdata;
  logic               pready, slv_err, launch;

  assign psel1 = psel & ~paddr[SLV_SEL_BIT];
  assign psel2 = psel &  paddr[SLV_SEL_BIT];

  // Response mux follows the latched select bit.
  assign pready  = paddr[SLV_SEL_BIT] ? pready2 : pready1;
  assign prdata  = paddr[SLV_SEL_BIT] ? prdata2 : prdata1;
  assign slv_err = paddr[SLV_SEL_BIT] ? err2    : err1;

  // A new transfer starts from IDLE, or straight out of a completing ACCESS.
  assign launch = usr.transfer &
                  ((state == IDLE) | ((state == ACCESS) & pready));

  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pslverr_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: ;
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: if (pready) begin
          pslverr_q <= slv_err;
          if (!pwrite && !slv_err) rdata_q <= prdata;
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // Overrides the IDLE/ACCESS next-state above when chaining.
      if (launch) begin
        state   <= SETUP;
        psel    <= 1'b1;
        penable <= 1'b0;
        pwrite  <= ~usr.READ_WRITE;
        paddr   <= usr.READ_WRITE ? usr.apb_read_paddr : usr.apb_write_paddr;
        pwdata  <= usr.apb_write_data;
      end
    end
  end

  assign usr.PSLVERR           = pslverr_q;
  assign usr.apb_read_data_out = rdata_q;

  apb_slave u_slv1 (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .psel    (psel1),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr[SLV_SEL_BIT-1:0]),
    .pwdata  (pwdata),
    .pready  (pready1),
    .prdata  (prdata1),
    .pslverr (err1)
  );

  apb_slave u_slv2 (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .psel    (psel2),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr[SLV_SEL_BIT-1:0]),
    .pwdata  (pwdata),
    .pready  (pready2),
    .prdata  (prdata2),
    .pslverr (err2)
  );
endmodule

// File: tb/tb_apb_protocol.sv
// Scoreboard bench for apb_protocol: every launched transfer pushes its
// predicted {PSLVERR, apb_read_data_out}, checked two edges after launch.
module tb_apb_protocol;
  import apb_pkg::*;

  logic PCLK = 1'b0;
  logic PRESETn;
  apb_protocol_if bus();

  apb_protocol dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .usr     (bus)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model
  logic [7:0] m_mem [2][64];
  bit         m_vld [2][64];
  logic [7:0] m_rd;

  typedef struct {
    int         due;
    logic       err;
    logic [7:0] rd;
    logic [8:0] addr;
  } exp_t;
  exp_t sb[$];

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 64; i++) m_vld[s][i] = 1'b0;
    m_rd = 8'h00;
  endtask

  task automatic model_push(input bit rd, input logic [8:0] a, input logic [7:0] d);
    exp_t e;
    int   s, ix;
    bit   bad;
    s   = int'(a[8]);
    ix  = int'(a[5:0]);
    bad = (a[7:6] != 2'b00);
    if (!rd) begin
      e.err = bad;
      if (!bad) begin
        m_mem[s][ix] = d;
        m_vld[s][ix] = 1'b1;
      end
    end else begin
      e.err = bad | !m_vld[s][ix];
      if (!e.err) m_rd = m_mem[s][ix];
    end
    e.rd   = m_rd;
    e.addr = a;
    e.due  = cyc + 2;
    sb.push_back(e);
  endtask

  // Completion monitor, sampling on the falling edge.
  always @(negedge PCLK) begin
    if (sb.size() != 0) begin
      if (sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("err@%03h", e.addr), 32'(bus.PSLVERR), 32'(e.err));
        chk($sformatf("rdata@%03h", e.addr), 32'(bus.apb_read_data_out), 32'(e.rd));
      end else if (sb[0].due < cyc) begin
        chk("sb_late", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
    end
  end

  // One transfer: inputs set now, launch on next edge, inputs scrambled
  // right after launch. Returns just after the ACCESS-entering edge so the
  // next call can chain back-to-back.
  task automatic xfer(input bit rd, input logic [8:0] a, input logic [7:0] d, input bit last);
    bus.READ_WRITE      = rd;
    bus.apb_write_paddr = rd ? 9'($urandom) : a;
    bus.apb_read_paddr  = rd ? a : 9'($urandom);
    bus.apb_write_data  = d;
    bus.transfer        = 1'b1;
    @(posedge PCLK);
    #1;
    model_push(rd, a, d);
    bus.READ_WRITE      = 1'($urandom);
    bus.apb_write_paddr = 9'($urandom);
    bus.apb_read_paddr  = 9'($urandom);
    bus.apb_write_data  = 8'($urandom);
    bus.transfer        = !last;
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    PRESETn             = 1'b1;
    bus.transfer        = 1'b0;
    bus.READ_WRITE      = 1'b0;
    bus.apb_write_paddr = '0;
    bus.apb_write_data  = '0;
    bus.apb_read_paddr  = '0;
    model_reset();
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b0;
    chk("rst_err", 32'(bus.PSLVERR), 32'd0);
    chk("rst_rdata", 32'(bus.apb_read_data_out), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("idle_psel", 32'(dut.psel1 | dut.psel2), 32'd0);
    end

    // Slave 1 writes, then slave 2 writes and two extra slave-1 bytes.
    for (int i = 0; i < 8; i++) xfer(1'b0, 9'(i), 8'(2 * i), i == 7);
    idle(3);
    for (int i = 0; i < 8; i++) xfer(1'b0, 9'(9'h100 + i), 8'(i), 1'b0);
    xfer(1'b0, 9'h00E, 8'd9, 1'b0);
    xfer(1'b0, 9'h016, 8'd35, 1'b1);
    idle(3);

    // Read back both slaves and the extra bytes.
    for (int i = 0; i < 8; i++) xfer(1'b1, 9'(i), 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) xfer(1'b1, 9'(9'h100 + i), 8'h00, 1'b0);
    xfer(1'b1, 9'h00E, 8'h00, 1'b0);
    xfer(1'b1, 9'h016, 8'h00, 1'b0);

    // Read immediately after write to the same byte.
    xfer(1'b0, 9'h003, 8'hA5, 1'b0);
    xfer(1'b1, 9'h003, 8'h00, 1'b0);
    xfer(1'b0, 9'h106, 8'h3C, 1'b0);
    xfer(1'b1, 9'h106, 8'h00, 1'b0);

    // Error cases: never-written byte, out-of-range address.
    xfer(1'b1, 9'h02D, 8'h00, 1'b0);
    xfer(1'b0, 9'h0C1, 8'h77, 1'b0);
    xfer(1'b1, 9'h0C0, 8'h00, 1'b1);
    idle(3);

    // Reset seen on the ACCESS-ending edge of a write to 0x005.
    xfer(1'b0, 9'h005, 8'h5A, 1'b1);
    PRESETn = 1'b1;
    sb.delete();
    model_reset();
    @(posedge PCLK);
    #1;
    PRESETn = 1'b0;
    chk("midrst_err", 32'(bus.PSLVERR), 32'd0);
    chk("midrst_rdata", 32'(bus.apb_read_data_out), 32'd0);
    chk("midrst_state", 32'(dut.state), 32'(IDLE));
    xfer(1'b1, 9'h005, 8'h00, 1'b0);
    xfer(1'b1, 9'h000, 8'h00, 1'b1);
    idle(3);

    // Bounded drain of anything still outstanding.
    for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_protocol.md
# apb_protocol

Self-contained AMBA APB subsystem: one APB master bridge driven by a simple user request interface, plus two identical 8-bit register-file slaves on an internal APB bus. Address bit 8 selects the slave. User-side writes and reads are converted into standard two-phase APB transfers (SETUP, then ACCESS). Read data and error status are returned to the user side. Used as a standalone APB demonstrator and bus-protocol test vehicle.

## Interface
Parameters:
- ADDR_W, 9: user/APB address width; bit 8 is slave select.
- DATA_W, 8: data width.
- MEM_DEPTH, 64: bytes per slave; indexed by PADDR[5:0].

Ports:
- PCLK  in  1  single system clock; all logic on rising edge.
- PRESETn  in  1  synchronous, active-high reset (name kept per codebase); a high level at a PCLK rising edge resets the block.
- transfer  in  1  request; while high, the master issues back-to-back transfers.
- READ_WRITE  in  1  0 = write, 1 = read; sampled when a transfer is launched.
- apb_write_paddr  in  9  write address.
- apb_write_data  in  8  write data.
- apb_read_paddr  in  9  read address.
- PSLVERR  out  1  error status of the most recently completed transfer.
- apb_read_data_out  out  8  data of the most recently completed successful read.

## Operation
- Master FSM states:
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSELx=1, PENABLE=0.
  - ACCESS: PSELx=1, PENABLE=1.
- FSM transitions:
  - IDLE→SETUP when transfer=1.
  - SETUP→ACCESS always.
  - ACCESS→SETUP if transfer=1 and PREADY=1.
  - ACCESS→IDLE if transfer=0 and PREADY=1.
  - ACCESS holds while PREADY=0.
- On every edge that enters SETUP, the master latches:
  - PWRITE = ~READ_WRITE.
  - PADDR = READ_WRITE ? apb_read_paddr : apb_write_paddr.
  - PWDATA = apb_write_data.
  - These are held stable through ACCESS.
- Slave select: PADDR[8]=0 → slave 1 (PSEL1), PADDR[8]=1 → slave 2 (PSEL2). Exactly one PSELx is high in SETUP/ACCESS.
- Slave behaviour (both identical):
  - Zero wait states: PREADY=1 whenever PSEL and PENABLE are high.
  - Each location has a written-valid bit, cleared by reset.
  - Write in ACCESS, PADDR[7:6]==0: mem[PADDR[5:0]] ← PWDATA, valid set, PSLVERR=0.
  - Read in ACCESS, PADDR[7:6]==0 and location valid: PRDATA = mem[PADDR[5:0]], PSLVERR=0.
  - Error cases, PSLVERR=1:
    - PADDR[7:6]!=0: write discarded, or read returns 0.
    - Read of a location never written.
- Master completion, at the edge ending ACCESS with PREADY=1:
  - PSLVERR output ← slave PSLVERR.
  - For an error-free read, apb_read_data_out ← PRDATA.
  - A read error leaves apb_read_data_out unchanged.
  - Writes leave apb_read_data_out unchanged.
- User address inputs wider than 9 bits are truncated by the caller; the block sees only 9 bits.

## Timing
- Reset values: FSM=IDLE, PSEL/PENABLE=0, PADDR=0, PWDATA=0, PSLVERR=0, apb_read_data_out=0, all valid bits 0. Memory contents are undefined after reset.
- Each transfer takes exactly 2 PCLK cycles. Sustained throughput is one transfer per 2 cycles while transfer stays high.
- Latency: inputs are sampled at edge N (entering SETUP). Memory write, and apb_read_data_out/PSLVERR update, occur at edge N+2.
- Changing inputs between launches does not affect an in-flight transfer.
- Dropping transfer during SETUP or ACCESS does not abort: the current transfer completes, then the FSM goes to IDLE.
- Reset asserted mid-transfer: the transfer is abandoned and no memory write occurs, provided reset is seen at or before the ACCESS-ending edge. Reset wins over all other actions on the same edge.
- Read of an address written in the immediately preceding transfer returns the new data.

## Structure
- Package apb_pkg holds:
  - State enum {IDLE, SETUP, ACCESS}.
  - ADDR_W, DATA_W and MEM_DEPTH constants.
  - SLV_SEL_BIT=8.
- Sub-module apb_slave (memory, valid bits, PREADY/PRDATA/PSLVERR), instantiated twice.
- Master FSM and the read-data mux live in the top level.

## Test plan
- Reset held high for 2 cycles → all outputs 0, FSM IDLE. With transfer=0 after reset → no PSEL activity.
- Write slave 1: transfer=1, READ_WRITE=0, addresses 0x000..0x007 with data 2*i, each held 2 cycles → mem1[i]=2*i, PSLVERR=0.
- Write slave 2: addresses 0x100..0x107 with data i → mem2[i]=i. Also write 0x00E←9 and 0x016←35, both with PSLVERR=0.
- Read back:
  - READ_WRITE=1, reading 0x000..0x007 → apb_read_data_out = 0,2,4..14, each 2 cycles after its launch.
  - Reading 0x100..0x107 → 0..7.
- Read 0x02D (never written) → PSLVERR=1 and apb_read_data_out unchanged. Read 0x0C0 → PSLVERR=1.
- Assert PRESETn during ACCESS of a write to 0x005 → location stays invalid; a later read of 0x005 gives PSLVERR=1.
